// File: rtl/mem_responder_pkg.sv
// Shared defaults and state encoding for the CPU memory responder.
package mem_responder_pkg;

    localparam int unsigned ADDR_W_DEF = 15;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned STATE_W    = 2;

    localparam logic [DATA_W_DEF-1:0] INIT_VALUE_DEF = 16'h0000;

    typedef enum logic [STATE_W-1:0] {
        S_INIT  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Core-side memory bus: two read ports, one write port, and the ready flag.
interface mem_responder_if #(
    parameter int unsigned ADDR_W = mem_responder_pkg::ADDR_W_DEF,
    parameter int unsigned DATA_W = mem_responder_pkg::DATA_W_DEF
) ();

    logic              ready;
    logic [ADDR_W-1:0] raddr0;
    logic [DATA_W-1:0] rdata0;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    modport master (
        input  ready, rdata0, rdata1,
        output raddr0, raddr1, wen, waddr, wdata
    );

    modport slave (
        input  raddr0, raddr1, wen, waddr, wdata,
        output ready, rdata0, rdata1
    );

endinterface

// File: rtl/mem_responder_array.sv
// DEPTH x DATA_W storage: one write port and two registered read ports.
// A read reflects writes committed on earlier edges only; gated reads return 0.
module mem_responder_array #(
    parameter int unsigned DEPTH  = 32768,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IDX_W  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rd_en,
    input  logic [IDX_W-1:0]  i_raddr0,
    input  logic [IDX_W-1:0]  i_raddr1,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1,
    input  logic              i_wen,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    always_ff @(posedge clk) begin
        if (i_wen) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (i_rd_en) begin
            r_rdata0 <= r_mem[i_raddr0];
            r_rdata1 <= r_mem[i_raddr1];
        end else begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end
    end

    assign o_rdata0 = r_rdata0;
    assign o_rdata1 = r_rdata1;

endmodule

// File: rtl/mem_responder.sv
// Responder for the CPU fetch/load/store ports: two-edge read latency,
// with a reset-time clear sequence gating ready.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned       ADDR_W         = ADDR_W_DEF,
    parameter int unsigned       DATA_W         = DATA_W_DEF,
    parameter int unsigned       DEPTH          = 32768,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VALUE     = DATA_W'(INIT_VALUE_DEF),
    parameter string             HEX_FILE       = ""
) (
    input logic            clk,
    input logic            rst_n,
    mem_responder_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
        $error("mem_responder: DEPTH must be a power of two within the address space");
    end

    // A preloaded image would be overwritten by the clear sequence.
    if (HEX_FILE != "" && CLEAR_ON_RESET) begin : g_bad_hex
        $error("mem_responder: HEX_FILE requires CLEAR_ON_RESET=0");
    end

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_ctr;
    logic [IDX_W-1:0]   r_raddr0;
    logic [IDX_W-1:0]   r_raddr1;
    logic               r_ready;
    logic               w_run;
    logic               w_clr_we;
    logic               w_ctr_last;
    logic               w_we;
    logic [IDX_W-1:0]   w_waddr;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_unused_addr;

    assign w_ctr_last = (r_ctr == IDX_W'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:  w_next = CLEAR_ON_RESET ? S_CLEAR : S_RUN;
            S_CLEAR: if (w_ctr_last) w_next = S_RUN;
            S_RUN:   w_next = S_RUN;
            default: w_next = S_INIT;
        endcase
    end

    always_comb begin
        w_run    = 1'b0;
        w_clr_we = 1'b0;
        case (r_state)
            S_CLEAR: w_clr_we = 1'b1;
            S_RUN:   w_run    = 1'b1;
            default: ;
        endcase
    end

    // Clear counter, stage-1 read addresses and the registered ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctr    <= '0;
            r_raddr0 <= '0;
            r_raddr1 <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_ctr    <= w_clr_we ? r_ctr + IDX_W'(1) : '0;
            r_raddr0 <= bus.raddr0[IDX_W-1:0];
            r_raddr1 <= bus.raddr1[IDX_W-1:0];
            r_ready  <= (w_next == S_RUN);
        end
    end

    // Clear sequencer owns the write port until the run state is reached.
    assign w_we    = w_clr_we | (w_run & bus.wen);
    assign w_waddr = w_clr_we ? r_ctr : bus.waddr[IDX_W-1:0];
    assign w_wdata = w_clr_we ? INIT_VALUE : bus.wdata;

    // Address bits above the storage index alias by design.
    assign w_unused_addr = ^{bus.raddr0, bus.raddr1, bus.waddr};

    mem_responder_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_rd_en  (w_run),
        .i_raddr0 (r_raddr0),
        .i_raddr1 (r_raddr1),
        .o_rdata0 (bus.rdata0),
        .o_rdata1 (bus.rdata1),
        .i_wen    (w_we),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata)
    );

    assign bus.ready = r_ready;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder with DEPTH=16 and INIT_VALUE=16'hdead.
module tb_mem_responder;

    logic clk;
    logic rst_n;
    logic iss0;
    logic iss1;
    logic [1:0] r_p0;
    logic [1:0] r_p1;
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int n_checks = 0;
    int n_fail   = 0;

    mem_responder_if #(.ADDR_W(15), .DATA_W(16)) bus ();

    mem_responder #(
        .ADDR_W         (15),
        .DATA_W         (16),
        .DEPTH          (16),
        .CLEAR_ON_RESET (1'b1),
        .INIT_VALUE     (16'hdead),
        .HEX_FILE       ("")
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Issue-flag pipeline: a read issued before edge E is due after edge E+1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p0 <= 2'b00;
            r_p1 <= 2'b00;
        end else begin
            r_p0 <= {r_p0[0], iss0};
            r_p1 <= {r_p1[0], iss1};
        end
    end

    always @(negedge clk) begin
        if (r_p0[1]) begin
            if (q0.size() == 0) check("q0 underflow", 16'h0001, 16'h0000);
            else check("rdata0", bus.rdata0, q0.pop_front());
        end
        if (r_p1[1]) begin
            if (q1.size() == 0) check("q1 underflow", 16'h0001, 16'h0000);
            else check("rdata1", bus.rdata1, q1.pop_front());
        end
    end

    task automatic cyc(input logic r0, input logic [14:0] a0, input logic [15:0] e0,
                       input logic r1, input logic [14:0] a1, input logic [15:0] e1,
                       input logic we, input logic [14:0] wa, input logic [15:0] wd);
        bus.raddr0 = a0;
        bus.raddr1 = a1;
        bus.wen    = we;
        bus.waddr  = wa;
        bus.wdata  = wd;
        iss0       = r0;
        iss1       = r1;
        if (r0) q0.push_back(e0);
        if (r1) q1.push_back(e1);
        @(negedge clk);
    endtask

    task automatic drain();
        repeat (3) cyc(0, 15'd0, 16'h0, 0, 15'd0, 16'h0, 0, 15'd0, 16'h0);
    endtask

    // Release reset at a falling edge with a store pending; ready must rise at edge 17.
    task automatic release_and_clear(input string tag);
        bus.wen    = 1'b1;
        bus.waddr  = 15'd5;
        bus.wdata  = 16'h1111;
        bus.raddr0 = 15'd5;
        bus.raddr1 = 15'd6;
        iss0       = 1'b0;
        iss1       = 1'b0;
        rst_n      = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            check($sformatf("%s ready edge %0d", tag, i), 16'(bus.ready), (i == 17) ? 16'h0001 : 16'h0000);
            if (i < 17) check($sformatf("%s gated rdata0 edge %0d", tag, i), bus.rdata0, 16'h0000);
        end
        bus.wen = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk        = 1'b0;
        rst_n      = 1'b0;
        iss0       = 1'b0;
        iss1       = 1'b0;
        bus.raddr0 = '0;
        bus.raddr1 = '0;
        bus.wen    = 1'b0;
        bus.waddr  = '0;
        bus.wdata  = '0;
        repeat (3) @(negedge clk);
        check("reset ready", 16'(bus.ready), 16'h0000);
        check("reset rdata0", bus.rdata0, 16'h0000);
        check("reset rdata1", bus.rdata1, 16'h0000);

        release_and_clear("init");

        // Every word holds the clear value, including word 5 targeted during clear.
        for (int i = 0; i < 16; i++)
            cyc(1, 15'(i), 16'hdead, 1, 15'(15 - i), 16'hdead, 0, 15'd0, 16'h0);
        drain();

        // Same-edge write and read of one word returns the new data.
        cyc(1, 15'd3, 16'h1234, 0, 15'd0, 16'h0, 1, 15'd3, 16'h1234);
        drain();

        // Read sampled before a later write keeps the old data.
        cyc(0, 15'd0, 16'h0, 0, 15'd0, 16'h0, 1, 15'd5, 16'h0001);
        cyc(1, 15'd5, 16'h0001, 0, 15'd0, 16'h0, 0, 15'd0, 16'h0);
        cyc(1, 15'd5, 16'h00ff, 1, 15'd5, 16'h00ff, 1, 15'd5, 16'h00ff);
        drain();

        // Streaming port 0 against a held address on port 1.
        for (int i = 0; i < 4; i++)
            cyc(0, 15'd0, 16'h0, 0, 15'd0, 16'h0, 1, 15'(i), 16'ha000 + 16'(i));
        for (int i = 0; i < 4; i++)
            cyc(1, 15'(i), 16'ha000 + 16'(i), 1, 15'd2, 16'ha002, 0, 15'd0, 16'h0);
        drain();

        // Upper address bits alias onto the low index.
        cyc(1, 15'h0003, 16'hbeef, 0, 15'd0, 16'h0, 1, 15'h0013, 16'hbeef);
        cyc(1, 15'h0012, 16'ha002, 1, 15'h7ff3, 16'hbeef, 0, 15'd0, 16'h0);
        drain();

        // Asynchronous reset mid-operation.
        cyc(0, 15'd0, 16'h0, 0, 15'd2, 16'h0, 0, 15'd0, 16'h0);
        cyc(0, 15'd0, 16'h0, 0, 15'd2, 16'h0, 0, 15'd0, 16'h0);
        check("pre-reset rdata0", bus.rdata0, 16'ha000);
        check("pre-reset rdata1", bus.rdata1, 16'ha002);
        #1 rst_n = 1'b0;
        #1;
        check("async reset ready", 16'(bus.ready), 16'h0000);
        check("async reset rdata0", bus.rdata0, 16'h0000);
        check("async reset rdata1", bus.rdata1, 16'h0000);
        @(negedge clk);
        release_and_clear("rerun");

        cyc(1, 15'd0, 16'hdead, 1, 15'd3, 16'hdead, 0, 15'd0, 16'h0);
        cyc(1, 15'd2, 16'hdead, 1, 15'd5, 16'hdead, 0, 15'd0, 16'h0);
        drain();

        check("q0 drained", 16'(q0.size()), 16'h0000);
        check("q1 drained", 16'(q1.size()), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
